// File: rtl/keyer_pkg.sv
// Shared symbol codes, FSM states and element timing multipliers for the keyer.
package keyer_pkg;

  typedef enum logic [1:0] {
    SYM_DOT      = 2'd0,
    SYM_DASH     = 2'd1,
    SYM_CHAR_GAP = 2'd2,
    SYM_WORD_GAP = 2'd3
  } sym_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KEY_ON  = 2'd1,
    S_KEY_OFF = 2'd2,
    S_GAP     = 2'd3
  } state_e;

  localparam int unsigned MUL_DOT      = 1;
  localparam int unsigned MUL_DASH     = 3;
  localparam int unsigned MUL_OFF      = 1;
  localparam int unsigned MUL_CHAR_GAP = 2;
  localparam int unsigned MUL_WORD_GAP = 6;
  localparam int unsigned MUL_W        = 3;

  // Units spent in the first phase of a symbol (key-down for marks, silence for gaps).
  function automatic logic [MUL_W-1:0] sym_units(sym_e s);
    logic [MUL_W-1:0] u;
    case (s)
      SYM_DOT:      u = MUL_W'(MUL_DOT);
      SYM_DASH:     u = MUL_W'(MUL_DASH);
      SYM_CHAR_GAP: u = MUL_W'(MUL_CHAR_GAP);
      default:      u = MUL_W'(MUL_WORD_GAP);
    endcase
    return u;
  endfunction

  function automatic logic sym_is_key(sym_e s);
    return (s == SYM_DOT) || (s == SYM_DASH);
  endfunction

endpackage

// File: rtl/keyer_gen_key_edge.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-time debounce, one-cycle
// pulse on the debounced falling (press) edge. Button is active-low.
module key_edge #(
  parameter int unsigned DEB_BITS = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic fall_o
);

  logic                sync1_q, sync2_q;
  logic                deb_q, deb_d;
  logic                fall_q, fall_d;
  logic [DEB_BITS-1:0] cnt_q, cnt_d;

  // The debounced level only follows the synchronised input after it has
  // differed for 2^DEB_BITS consecutive cycles; any bounce restarts the count.
  always_comb begin
    cnt_d  = '0;
    deb_d  = deb_q;
    fall_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == '1) begin
        deb_d  = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + DEB_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/keyer_gen.sv
// Morse keyer: buffers DOT/DASH/gap symbols and plays them on an active-low key
// output at a button-selectable speed, single-shot or looping.
module keyer_gen
  import keyer_pkg::*;
#(
  parameter int unsigned N_SPEEDS  = 8,
  parameter int unsigned UNIT_BASE = 3000000,
  parameter int unsigned UNIT_STEP = 300000,
  parameter int unsigned MSG_DEPTH = 64,
  parameter int unsigned DEB_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sp_up,
  input  logic                sp_dwn,
  input  logic                wr_en,
  input  logic [1:0]          wr_sym,
  input  logic                clr,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  output logic                sw_out,
  output logic                busy,
  output logic                full,
  output logic [N_SPEEDS-1:0] ledr
);

  localparam int unsigned AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(N_SPEEDS);
  localparam int unsigned UW = $clog2(UNIT_BASE + 1);

  // ---------------- speed selection ----------------
  logic                up_p, dn_p;
  logic [SW-1:0]       speed_q, speed_d;
  logic [N_SPEEDS-1:0] ledr_q;
  logic [UW-1:0]       unit_len;

  key_edge #(.DEB_BITS(DEB_BITS)) u_up (
    .clk_i (clk),
    .rst_ni(reset),
    .btn_ni(sp_up),
    .fall_o(up_p)
  );

  key_edge #(.DEB_BITS(DEB_BITS)) u_dwn (
    .clk_i (clk),
    .rst_ni(reset),
    .btn_ni(sp_dwn),
    .fall_o(dn_p)
  );

  always_comb begin
    speed_d = speed_q;
    if (up_p && !dn_p && (speed_q != SW'(N_SPEEDS - 1))) begin
      speed_d = speed_q + SW'(1);
    end else if (dn_p && !up_p && (speed_q != '0)) begin
      speed_d = speed_q - SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_q <= '0;
      ledr_q  <= N_SPEEDS'(1);
    end else begin
      speed_q <= speed_d;
      ledr_q  <= N_SPEEDS'(1) << speed_d;
    end
  end

  assign ledr     = ledr_q;
  assign unit_len = UW'(UNIT_BASE) - UW'(speed_q) * UW'(UNIT_STEP);

  // ---------------- symbol buffer ----------------
  logic [1:0]    mem_q [MSG_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok;
  state_e        state_q, state_d;

  assign busy = (state_q != S_IDLE);
  assign full = (count_q == CW'(MSG_DEPTH));

  always_comb begin
    count_d = count_q;
    wr_ok   = 1'b0;
    if (!busy) begin
      if (clr) begin
        count_d = '0;
      end else if (wr_en && !full) begin
        count_d = count_q + CW'(1);
        wr_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[count_q[AW-1:0]] <= wr_sym;
  end

  // ---------------- playback FSM ----------------
  logic [AW-1:0]    idx_q, idx_d, load_idx;
  logic [UW-1:0]    ucnt_q, ucnt_d, ulen_q, ulen_d;
  logic [MUL_W-1:0] units_q, units_d;
  logic             load, elem_done, last_sym;
  sym_e             load_sym;

  assign elem_done = (ucnt_q == '0) && (units_q == '0);
  assign last_sym  = (({1'b0, idx_q} + CW'(1)) == count_q);

  // Each element latches its unit length on entry, so a speed change never
  // stretches or shrinks an element that is already running.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ucnt_d   = ucnt_q;
    units_d  = units_q;
    ulen_d   = ulen_q;
    load     = 1'b0;
    load_idx = '0;

    if (ucnt_q != '0) begin
      ucnt_d = ucnt_q - UW'(1);
    end else if (units_q != '0) begin
      units_d = units_q - MUL_W'(1);
      ucnt_d  = ulen_q - UW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start && (count_q != '0)) load = 1'b1;
      end
      S_KEY_ON: begin
        if (elem_done) begin
          state_d = S_KEY_OFF;
          ulen_d  = unit_len;
          ucnt_d  = unit_len - UW'(1);
          units_d = MUL_W'(MUL_OFF - 1);
        end
      end
      default: begin
        if (elem_done) begin
          if (!last_sym) begin
            load     = 1'b1;
            load_idx = idx_q + AW'(1);
          end else if (loop) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase

    load_sym = sym_e'(mem_q[load_idx]);
    if (load) begin
      idx_d   = load_idx;
      state_d = sym_is_key(load_sym) ? S_KEY_ON : S_GAP;
      ulen_d  = unit_len;
      ucnt_d  = unit_len - UW'(1);
      units_d = sym_units(load_sym) - MUL_W'(1);
    end

    if (stop) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ucnt_q  <= '0;
      ulen_q  <= '0;
      units_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ucnt_q  <= ucnt_d;
      ulen_q  <= ulen_d;
      units_q <= units_d;
    end
  end

  assign sw_out = (state_q != S_KEY_ON);

endmodule

// File: tb/tb_keyer_gen.sv
// Self-checking bench for keyer_gen: control table, scripted corner cases and
// randomized messages checked against a per-cycle key waveform model.
module tb_keyer_gen;

  localparam int NS    = 8;
  localparam int UB    = 16;
  localparam int US    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sp_up = 1'b1, sp_dwn = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_sym = 2'd0;
  logic          clr = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic          sw_out, busy, full;
  logic [NS-1:0] ledr;

  int checks = 0;
  int failures = 0;
  int spd = 0;
  logic [1:0] msg[$];
  bit exp_q[$];

  keyer_gen #(
    .N_SPEEDS (NS),
    .UNIT_BASE(UB),
    .UNIT_STEP(US),
    .MSG_DEPTH(DEPTH),
    .DEB_BITS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sp_up (sp_up),
    .sp_dwn(sp_dwn),
    .wr_en (wr_en),
    .wr_sym(wr_sym),
    .clr   (clr),
    .start (start),
    .stop  (stop),
    .loop  (loop),
    .sw_out(sw_out),
    .busy  (busy),
    .full  (full),
    .ledr  (ledr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [1:0] sym;
    logic       cl;
    logic       st;
    logic       sp;
    logic       eb;
    logic       ef;
    logic       es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic [1:0] sym, logic cl, logic st, logic sp,
                              logic eb, logic ef, logic es);
    vec_t v;
    v.wr = wr; v.sym = sym; v.cl = cl; v.st = st; v.sp = sp;
    v.eb = eb; v.ef = ef; v.es = es;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic press(input bit up, input bit dn);
    sp_up  = !up;
    sp_dwn = !dn;
    repeat (20) tick();
    sp_up  = 1'b1;
    sp_dwn = 1'b1;
    repeat (20) tick();
    if (up && !dn && spd < NS - 1) spd++;
    else if (dn && !up && spd > 0) spd--;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic write_msg();
    foreach (msg[k]) begin
      wr_en  = 1'b1;
      wr_sym = msg[k];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Expected key level per cycle from the symbol timing rules.
  task automatic build_exp(input int passes);
    int u, on_len, off_len;
    u = UB - US * spd;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      foreach (msg[k]) begin
        case (msg[k])
          2'd0:    begin on_len = u;     off_len = u;     end
          2'd1:    begin on_len = 3 * u; off_len = u;     end
          2'd2:    begin on_len = 0;     off_len = 2 * u; end
          default: begin on_len = 0;     off_len = 6 * u; end
        endcase
        for (int c = 0; c < on_len; c++) exp_q.push_back(1'b0);
        for (int c = 0; c < off_len; c++) exp_q.push_back(1'b1);
      end
    end
  endtask

  task automatic play(input int passes, input int stop_at, input string name);
    int errs, n;
    errs = 0;
    build_exp(passes);
    n = (stop_at >= 0) ? stop_at : exp_q.size();
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      start = 1'b0;
      if (sw_out !== exp_q[i] || busy !== 1'b1) errs++;
    end
    check({name, "_wave_errs"}, errs, 0);
    if (stop_at >= 0) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end else begin
      tick();
    end
    check({name, "_end_busy"}, int'(busy), 0);
    check({name, "_end_sw"}, int'(sw_out), 1);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    check("rst_sw", int'(sw_out), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_full", int'(full), 0);
    check("rst_ledr", int'(ledr), 1);
    reset = 1'b1;
    tick();

    // Single-cycle control table (buffer depth 8, unit 16).
    for (int i = 0; i < DEPTH - 1; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    foreach (tbl[i]) begin
      wr_en = tbl[i].wr; wr_sym = tbl[i].sym; clr = tbl[i].cl;
      start = tbl[i].st; stop = tbl[i].sp;
      tick();
      wr_en = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0;
      check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
      check($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].ef));
      check($sformatf("tbl%0d_sw", i), int'(sw_out), int'(tbl[i].es));
    end
    // Buffer should hold exactly one DOT: busy-time clr and write were dropped.
    msg = '{2'd0};
    play(1, -1, "retained");

    do_clr();
    msg = '{2'd0, 2'd1};
    write_msg();
    play(1, -1, "dot_dash");

    for (int i = 0; i < 8; i++) press(0, 1);
    check("dwn_sat_ledr", int'(ledr), 1);
    for (int i = 0; i < 3; i++) press(1, 0);
    check("up3_ledr", int'(ledr), 8);
    do_clr();
    msg = '{2'd0};
    write_msg();
    play(1, -1, "dot_speed3");
    for (int i = 0; i < 6; i++) press(1, 0);
    check("up_sat_ledr", int'(ledr), 128);
    press(1, 1);
    check("both_ledr", int'(ledr), 128);

    for (int it = 0; it < 8; it++) begin
      int r, len;
      do_clr();
      r = $urandom_range(0, 3);
      press(r == 1 || r == 3, r == 2 || r == 3 || it < 3);
      check("rand_ledr", int'(ledr), 1 << spd);
      len = $urandom_range(1, DEPTH);
      msg.delete();
      for (int k = 0; k < len; k++) msg.push_back(2'($urandom_range(0, 3)));
      write_msg();
      check("rand_full", int'(full), int'(len == DEPTH));
      play(1, -1, "rand");
    end

    do_clr();
    msg.delete();
    for (int k = 0; k < DEPTH; k++) msg.push_back(2'($urandom_range(0, 2)));
    write_msg();
    check("full_at_depth", int'(full), 1);
    wr_en = 1'b1; wr_sym = 2'd3;
    tick();
    wr_en = 1'b0;
    check("full_after_extra", int'(full), 1);
    play(1, -1, "full_play");

    do_clr();
    msg = '{2'd0, 2'd3};
    write_msg();
    loop = 1'b1;
    build_exp(1);
    play(2, exp_q.size() + exp_q.size() / 2, "loop_stop");
    loop = 1'b0;
    play(1, -1, "replay");

    do_clr();
    msg = '{2'd1};
    write_msg();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("pre_rst_sw", int'(sw_out), 0);
    #3 reset = 1'b0;
    #1;
    check("async_rst_sw", int'(sw_out), 1);
    check("async_rst_busy", int'(busy), 0);
    spd = 0;
    repeat (2) tick();
    check("rst2_ledr", int'(ledr), 1);
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_after_rst_busy", int'(busy), 0);
    repeat (3) tick();
    check("start_after_rst_sw", int'(sw_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
